alarm_buzzer_sched: RTL and testbench
=====================================

# alarm_buzzer_sched

Single-buzzer scheduler for the alarm clock. Arbitrates three sound requesters (key click, hourly chime, alarm) onto one `buzzer` output and generates their timed patterns from the 100 Hz tick. It also sequences the alarm life cycle: beeping, snooze, stop and auto-timeout. It sits between the timekeeping/compare logic and the buzzer driver pin.

## Interface
- `CLICK_TICKS`, default 5: click length (50 ms).
- `CHIME_TICKS`, default 100: chime length (1 s).
- `BEEP_TICKS`, default 50: alarm on-phase and off-phase length each.
- `SNOOZE_TICKS`, default 30000: snooze length (5 min). Counter width is 15 bits.
- `MAX_BEEPS`, default 120: on-phases before auto-stop.
- `clk_100Hz`, in, 1: clock.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `click_req`, in, 1: key-click request pulse.
- `chime_req`, in, 1: hourly chime request pulse.
- `alarm_req`, in, 1: alarm-match pulse.
- `snooze`, in, 1: snooze button pulse. Already debounced, one cycle.
- `stop`, in, 1: stop button pulse. Already debounced, one cycle.
- `buzzer`, out, 1: buzzer drive.
- `grant`, out, 2: current owner. 0 none, 1 click, 2 chime, 3 alarm.
- `alarm_active`, out, 1: high while in ALARM_ON, ALARM_OFF or SNOOZE.
- `alarm_missed`, out, 1: set on alarm auto-timeout.

## Operation
- States: IDLE, CLICK, CHIME, ALARM_ON, ALARM_OFF, SNOOZE.
- One tick counter (`tcnt`) and one beep counter (`bcnt`). Both are loaded on state entry.
- Event priority within one cycle: stop > alarm_req > snooze > chime > click.
- `stop`:
  - From any alarm state, go to IDLE.
  - Clears `alarm_missed`.
  - Elsewhere, `stop` only clears `alarm_missed`.
- `alarm_req`:
  - From IDLE, CLICK or CHIME, go to ALARM_ON and set `bcnt`=0.
  - A CLICK or CHIME in progress is aborted and not resumed.
  - Ignored while `alarm_active`.
- ALARM_ON:
  - After BEEP_TICKS cycles, go to ALARM_OFF and increment `bcnt`.
  - If `bcnt` reaches MAX_BEEPS at that point, go to IDLE instead and set `alarm_missed`.
- ALARM_OFF: after BEEP_TICKS cycles, go to ALARM_ON.
- `snooze`:
  - In ALARM_ON or ALARM_OFF, go to SNOOZE and reset `bcnt`=0.
  - Ignored in every other state.
- SNOOZE: `buzzer` is low. After SNOOZE_TICKS cycles, go to ALARM_ON.
- `chime_req`:
  - From IDLE, go to CHIME.
  - In CLICK, it is latched into a one-deep `chime_pend` and taken when CLICK ends.
  - While `alarm_active`, it is latched into `chime_pend`.
  - `chime_pend` is discarded when the alarm is stopped or times out.
  - A repeat request while `chime_pend` is already set has no effect.
- `click_req`:
  - From IDLE, go to CLICK.
  - In CLICK, the click is restarted with the full length.
  - In CHIME or any alarm state, it is dropped. No pending flag.
- CLICK and CHIME end to IDLE, or to CHIME if `chime_pend` is set (which clears it).
- `buzzer` is high in CLICK, CHIME and ALARM_ON. It is low otherwise.
- `grant` is 1 in CLICK, 2 in CHIME, 3 in the alarm states, and 0 in IDLE.

## Timing
- Reset values:
  - State IDLE.
  - `buzzer`=0, `grant`=0, `alarm_active`=0, `alarm_missed`=0.
  - `chime_pend`=0, `tcnt`=0, `bcnt`=0.
- All outputs are registered.
- A request sampled at edge N drives `buzzer` from after edge N through edge N+L. This gives exactly L high cycles, where L is the phase length parameter.
- Phase lengths are exact in cycles.
- ALARM_ON to ALARM_OFF and back has no gap cycle.
- SNOOZE lasts exactly SNOOZE_TICKS low cycles before the next ALARM_ON.
- Reset mid-operation aborts immediately to reset values. No pending request survives.

## Configuration
- `ALARM_BUZZER_SCHED_MISSED_EN`
  - Defined: `alarm_missed` behaves as above.
  - Undefined: auto-timeout still returns to IDLE, but `alarm_missed` is tied to 0 and its flop is removed.

## Structure
- Shared package `alarm_pkg`:
  - State enum.
  - `grant` source codes (GRANT_NONE/CLICK/CHIME/ALARM).
  - 15-bit tick-count type.
- One sub-module, `buzz_timer`:
  - Loadable 15-bit down-counter clocked by `clk_100Hz`.
  - Inputs: `load`, `len`. Output: `done`, high in the last cycle of the phase.
  - The FSM owns `bcnt` and `chime_pend`.

## Test plan
- `click_req` in IDLE → `buzzer` high 5 cycles, `grant`=1, then 0. Second `click_req` at cycle 3 → high 3+5 cycles total.
- `chime_req` during CLICK → CLICK finishes, then 100 cycles of CHIME with no gap. `grant` goes 1 → 2 → 0.
- `alarm_req` during CHIME → immediate ALARM_ON. Buzzer pattern 50 high / 50 low. `stop` → IDLE, `buzzer`=0 next cycle.
- `snooze` in ALARM_OFF → `buzzer` low for 30000 cycles, `alarm_active`=1 throughout, then ALARM_ON again. `chime_req` during SNOOZE is held and discarded on `stop`.
- No `stop` for 120 beeps → IDLE, `alarm_missed`=1 (0 with macro undefined). Later `stop` clears it.
- Assert `rst_n` low mid-ALARM_ON → all outputs 0 asynchronously. After release, `chime_req` gives a normal 100-cycle chime.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types for the alarm buzzer scheduler: FSM states, grant codes,
// tick-count type and small state decode helpers.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLICK,
        CHIME,
        ALARM_ON,
        ALARM_OFF,
        SNOOZE
    } state_t;

    localparam logic [1:0] GRANT_NONE  = 2'd0;
    localparam logic [1:0] GRANT_CLICK = 2'd1;
    localparam logic [1:0] GRANT_CHIME = 2'd2;
    localparam logic [1:0] GRANT_ALARM = 2'd3;

    localparam int TICK_W = 15;
    typedef logic [TICK_W-1:0] tick_t;

    // Which requester owns the buzzer in a given state
    function automatic logic [1:0] grant_of(state_t s);
        case (s)
            CLICK:                        return GRANT_CLICK;
            CHIME:                        return GRANT_CHIME;
            ALARM_ON, ALARM_OFF, SNOOZE:  return GRANT_ALARM;
            default:                      return GRANT_NONE;
        endcase
    endfunction

    // True for every state that belongs to the alarm life cycle
    function automatic logic is_alarm(state_t s);
        return (s == ALARM_ON) || (s == ALARM_OFF) || (s == SNOOZE);
    endfunction

    // True for every state that drives the buzzer high
    function automatic logic sounds(state_t s);
        return (s == CLICK) || (s == CHIME) || (s == ALARM_ON);
    endfunction

endpackage

// File: rtl/buzz_timer.sv
// Loadable 15-bit phase down-counter. Loading a length L makes 'done'
// rise in the L-th cycle after the load edge, i.e. the last phase cycle.
module buzz_timer
    import alarm_pkg::*;
(
    input  logic  clk_100Hz,
    input  logic  rst_n,
    input  logic  load,
    input  tick_t len,
    output logic  done
);

    tick_t tcnt_q;

    // Load len-1 so that a zero count marks the final cycle of the phase
    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if (load) begin
            tcnt_q <= len - tick_t'(1);
        end else if (tcnt_q != '0) begin
            tcnt_q <= tcnt_q - tick_t'(1);
        end
    end

    assign done = (tcnt_q == '0);

endmodule

// File: rtl/alarm_buzzer_sched.sv
// Single-buzzer scheduler: arbitrates click, chime and alarm requests and
// sequences the alarm beep/snooze/timeout cycle from the 100 Hz tick.
// Optional feature macro: ALARM_BUZZER_SCHED_MISSED_EN keeps the sticky
// alarm_missed flag; without it the flag is tied low.
module alarm_buzzer_sched
    import alarm_pkg::*;
#(
    parameter int CLICK_TICKS  = 5,
    parameter int CHIME_TICKS  = 100,
    parameter int BEEP_TICKS   = 50,
    parameter int SNOOZE_TICKS = 30000,
    parameter int MAX_BEEPS    = 120
) (
    input  logic       clk_100Hz,
    input  logic       rst_n,
    input  logic       click_req,
    input  logic       chime_req,
    input  logic       alarm_req,
    input  logic       snooze,
    input  logic       stop,
    output logic       buzzer,
    output logic [1:0] grant,
    output logic       alarm_active,
    output logic       alarm_missed
);

    localparam int    BW         = $clog2(MAX_BEEPS + 1);
    localparam tick_t CLICK_LEN  = tick_t'(CLICK_TICKS);
    localparam tick_t CHIME_LEN  = tick_t'(CHIME_TICKS);
    localparam tick_t BEEP_LEN   = tick_t'(BEEP_TICKS);
    localparam tick_t SNOOZE_LEN = tick_t'(SNOOZE_TICKS);

    state_t        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          pend_q, pend_d;
    logic          tmr_load;
    tick_t         tmr_len;
    logic          tmr_done;
    logic          in_alarm;
    logic          buzzer_q;
    logic [1:0]    grant_q;
    logic          active_q;
`ifdef ALARM_BUZZER_SCHED_MISSED_EN
    logic          timeout;
    logic          missed_q;
`endif

    buzz_timer u_timer (
        .clk_100Hz (clk_100Hz),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .len       (tmr_len),
        .done      (tmr_done)
    );

    assign in_alarm = is_alarm(state_q);

    // Next-state decode: events in priority order, then phase expiry
    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        pend_d   = pend_q;
        tmr_load = 1'b0;
        tmr_len  = '0;
`ifdef ALARM_BUZZER_SCHED_MISSED_EN
        timeout  = 1'b0;
`endif
        if (chime_req && (in_alarm || state_q == CLICK)) begin
            pend_d = 1'b1;
        end
        if (stop && in_alarm) begin
            state_d = IDLE;
            pend_d  = 1'b0;
        end else if (alarm_req && !in_alarm) begin
            state_d  = ALARM_ON;
            bcnt_d   = '0;
            tmr_load = 1'b1;
            tmr_len  = BEEP_LEN;
        end else if (snooze && (state_q == ALARM_ON || state_q == ALARM_OFF)) begin
            state_d  = SNOOZE;
            bcnt_d   = '0;
            tmr_load = 1'b1;
            tmr_len  = SNOOZE_LEN;
        end else begin
            case (state_q)
                IDLE: begin
                    if (chime_req) begin
                        state_d  = CHIME;
                        tmr_load = 1'b1;
                        tmr_len  = CHIME_LEN;
                    end else if (click_req) begin
                        state_d  = CLICK;
                        tmr_load = 1'b1;
                        tmr_len  = CLICK_LEN;
                    end
                end
                CLICK: begin
                    if (click_req) begin
                        tmr_load = 1'b1;
                        tmr_len  = CLICK_LEN;
                    end else if (tmr_done) begin
                        if (pend_d) begin
                            state_d  = CHIME;
                            pend_d   = 1'b0;
                            tmr_load = 1'b1;
                            tmr_len  = CHIME_LEN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                CHIME: begin
                    if (tmr_done) begin
                        if (pend_q) begin
                            pend_d   = 1'b0;
                            tmr_load = 1'b1;
                            tmr_len  = CHIME_LEN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ALARM_ON: begin
                    if (tmr_done) begin
                        bcnt_d = bcnt_q + BW'(1);
                        if (bcnt_d == BW'(MAX_BEEPS)) begin
                            state_d = IDLE;
                            pend_d  = 1'b0;
`ifdef ALARM_BUZZER_SCHED_MISSED_EN
                            timeout = 1'b1;
`endif
                        end else begin
                            state_d  = ALARM_OFF;
                            tmr_load = 1'b1;
                            tmr_len  = BEEP_LEN;
                        end
                    end
                end
                ALARM_OFF, SNOOZE: begin
                    if (tmr_done) begin
                        state_d  = ALARM_ON;
                        tmr_load = 1'b1;
                        tmr_len  = BEEP_LEN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counters and outputs, all registered from the next state
    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bcnt_q   <= '0;
            pend_q   <= 1'b0;
            buzzer_q <= 1'b0;
            grant_q  <= GRANT_NONE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            pend_q   <= pend_d;
            buzzer_q <= sounds(state_d);
            grant_q  <= grant_of(state_d);
            active_q <= is_alarm(state_d);
        end
    end

`ifdef ALARM_BUZZER_SCHED_MISSED_EN
    // Sticky missed flag: set by auto-timeout, cleared by any stop press
    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            missed_q <= 1'b0;
        end else if (stop) begin
            missed_q <= 1'b0;
        end else if (timeout) begin
            missed_q <= 1'b1;
        end
    end
    assign alarm_missed = missed_q;
`else
    assign alarm_missed = 1'b0;
`endif

    assign buzzer       = buzzer_q;
    assign grant        = grant_q;
    assign alarm_active = active_q;

endmodule

// File: tb/tb_alarm_buzzer_sched.sv
// Scoreboard bench for alarm_buzzer_sched: stimulus pushes the expected
// output transitions (cycle and value) and a monitor pops one entry each
// time the DUT output vector changes.
module tb_alarm_buzzer_sched;

    localparam int SEL_CLICK  = 0;
    localparam int SEL_CHIME  = 1;
    localparam int SEL_ALARM  = 2;
    localparam int SEL_SNOOZE = 3;
    localparam int SEL_STOP   = 4;

`ifdef ALARM_BUZZER_SCHED_MISSED_EN
    localparam bit MISS_EXP = 1'b1;
`else
    localparam bit MISS_EXP = 1'b0;
`endif

    typedef struct {
        int         at;
        logic [4:0] v;
        string      tag;
    } exp_t;

    logic       clk_100Hz = 1'b0;
    logic       rst_n;
    logic       clickReq, chimeReq, alarmReq, snoozeBtn, stopBtn;
    logic       buzzer, alarmActive, alarmMissed;
    logic [1:0] grant;

    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       sbq[$];
    logic [4:0] lastSeen = '0;

    alarm_buzzer_sched dut (
        .clk_100Hz    (clk_100Hz),
        .rst_n        (rst_n),
        .click_req    (clickReq),
        .chime_req    (chimeReq),
        .alarm_req    (alarmReq),
        .snooze       (snoozeBtn),
        .stop         (stopBtn),
        .buzzer       (buzzer),
        .grant        (grant),
        .alarm_active (alarmActive),
        .alarm_missed (alarmMissed)
    );

    // 10-unit clock period
    always #5 clk_100Hz = ~clk_100Hz;

    // Rising-edge counter used as the time base for expectations
    always @(posedge clk_100Hz) cyc <= cyc + 1;

    function automatic logic [4:0] vec(bit b, int g, bit a, bit m);
        return {b, g[1:0], a, m};
    endfunction

    task automatic push(input int at, input logic [4:0] v, input string tag);
        sbq.push_back('{at, v, tag});
    endtask

    task automatic checkOutput(input string name, input logic [4:0] got, input logic [4:0] want,
                               input int gotAt, input int wantAt);
        total++;
        if (got !== want || gotAt != wantAt) begin
            bad++;
            $display("[TB] FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                     name, got, gotAt, want, wantAt);
        end
    endtask

    // One-cycle pulse on the selected input, driven from a falling edge
    task automatic applyStimulus(input int sel);
        case (sel)
            SEL_CLICK:  clickReq  = 1'b1;
            SEL_CHIME:  chimeReq  = 1'b1;
            SEL_ALARM:  alarmReq  = 1'b1;
            SEL_SNOOZE: snoozeBtn = 1'b1;
            default:    stopBtn   = 1'b1;
        endcase
        @(negedge clk_100Hz);
        clickReq  = 1'b0;
        chimeReq  = 1'b0;
        alarmReq  = 1'b0;
        snoozeBtn = 1'b0;
        stopBtn   = 1'b0;
    endtask

    task automatic waitTo(input int t);
        while (cyc < t) @(negedge clk_100Hz);
    endtask

    // Monitor: every change of the output vector consumes one expectation
    always @(negedge clk_100Hz) begin : monitor
        logic [4:0] cur;
        exp_t       e;
        cur = {buzzer, grant, alarmActive, alarmMissed};
        if (cur !== lastSeen) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_change", cur, lastSeen, cyc, cyc);
            end else begin
                e = sbq.pop_front();
                checkOutput(e.tag, cur, e.v, cyc, e.at);
            end
            lastSeen = cur;
        end
    end

    initial begin : stim
        int t;
        int t2;
        clickReq  = 1'b0;
        chimeReq  = 1'b0;
        alarmReq  = 1'b0;
        snoozeBtn = 1'b0;
        stopBtn   = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1 checkOutput("reset_values", {buzzer, grant, alarmActive, alarmMissed}, 5'b0, 0, 0);
        repeat (3) @(negedge clk_100Hz);
        rst_n = 1'b1;
        @(negedge clk_100Hz);

        // Single click from idle: five high cycles
        t = cyc;
        push(t + 1, vec(1, 1, 0, 0), "click_on");
        push(t + 6, vec(0, 0, 0, 0), "click_off");
        applyStimulus(SEL_CLICK);
        waitTo(t + 10);

        // Click restarted three cycles in: 3 + 5 high cycles
        t = cyc;
        push(t + 1, vec(1, 1, 0, 0), "reclick_on");
        push(t + 9, vec(0, 0, 0, 0), "reclick_off");
        applyStimulus(SEL_CLICK);
        waitTo(t + 3);
        applyStimulus(SEL_CLICK);
        waitTo(t + 15);

        // Chime during click runs right after the click with no gap
        t = cyc;
        push(t + 1,   vec(1, 1, 0, 0), "pend_click_on");
        push(t + 6,   vec(1, 2, 0, 0), "pend_chime_on");
        push(t + 106, vec(0, 0, 0, 0), "pend_chime_off");
        applyStimulus(SEL_CLICK);
        waitTo(t + 2);
        applyStimulus(SEL_CHIME);
        waitTo(t + 110);

        // Alarm aborts a chime, beeps 50/50, stop returns to idle
        t = cyc;
        push(t + 1,   vec(1, 2, 0, 0), "chime_on");
        push(t + 11,  vec(1, 3, 1, 0), "alarm_preempt");
        push(t + 61,  vec(0, 3, 1, 0), "beep_off");
        push(t + 111, vec(1, 3, 1, 0), "beep_on2");
        push(t + 131, vec(0, 0, 0, 0), "stop_idle");
        applyStimulus(SEL_CHIME);
        waitTo(t + 10);
        applyStimulus(SEL_ALARM);
        waitTo(t + 130);
        applyStimulus(SEL_STOP);
        waitTo(t + 140);

        // Snooze in the off phase, held chime discarded by stop
        t = cyc;
        push(t + 1,     vec(1, 3, 1, 0), "sn_alarm_on");
        push(t + 51,    vec(0, 3, 1, 0), "sn_beep_off");
        push(t + 30061, vec(1, 3, 1, 0), "snooze_end");
        push(t + 30071, vec(0, 0, 0, 0), "sn_stop_idle");
        applyStimulus(SEL_ALARM);
        waitTo(t + 60);
        applyStimulus(SEL_SNOOZE);
        waitTo(t + 100);
        applyStimulus(SEL_CHIME);
        waitTo(t + 30070);
        applyStimulus(SEL_STOP);
        waitTo(t + 30250);

        // 120 unanswered beeps time out; re-alarm, click and chime are ignored
        t = cyc;
        for (int i = 0; i < 120; i++) begin
            push(t + 1 + 100 * i, vec(1, 3, 1, 0), "to_beep_on");
            if (i < 119) push(t + 51 + 100 * i, vec(0, 3, 1, 0), "to_beep_off");
        end
        push(t + 11951, vec(0, 0, 0, MISS_EXP), "timeout_idle");
        if (MISS_EXP) push(t + 12001, vec(0, 0, 0, 0), "missed_clear");
        applyStimulus(SEL_ALARM);
        waitTo(t + 20);
        applyStimulus(SEL_ALARM);
        waitTo(t + 230);
        applyStimulus(SEL_CLICK);
        waitTo(t + 300);
        applyStimulus(SEL_CHIME);
        waitTo(t + 12000);
        applyStimulus(SEL_STOP);
        waitTo(t + 12010);

        // Asynchronous reset mid beep drops everything, including a held chime
        t = cyc;
        push(t + 1,  vec(1, 3, 1, 0), "rst_alarm_on");
        push(t + 21, vec(0, 0, 0, 0), "rst_outputs");
        applyStimulus(SEL_ALARM);
        waitTo(t + 10);
        applyStimulus(SEL_CHIME);
        waitTo(t + 20);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset", {buzzer, grant, alarmActive, alarmMissed}, 5'b0, 0, 0);
        waitTo(t + 23);
        rst_n = 1'b1;
        waitTo(t + 40);
        t2 = cyc;
        push(t2 + 1,   vec(1, 2, 0, 0), "post_rst_chime_on");
        push(t2 + 101, vec(0, 0, 0, 0), "post_rst_chime_off");
        applyStimulus(SEL_CHIME);
        waitTo(t2 + 110);

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("[TB] FAIL leftover_expectations: got %0d pending, required 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
